// File: rtl/bw_stream_filter.sv
// Three-stage valid/ready RGB-to-grey pipeline: average, luma, max-channel or threshold per pixel.
// Define BW_STREAM_STATS_EN to build the pix_cnt output-beat counter (tied to 0 otherwise).
module bw_stream_filter #(
  parameter int unsigned CW       = 8,
  parameter int unsigned ZERO_SUB = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3*CW-1:0] in_pixel,
  input  logic [1:0]      in_mode,
  input  logic [CW-1:0]   in_thr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_data,
  input  logic            clr_stats,
  output logic [31:0]     pix_cnt
);

  localparam int unsigned SW = CW + 2;   // sum width
  localparam int unsigned LW = CW + 10;  // luma width
  localparam int unsigned DK = SW + 1;   // reciprocal shift; exact for every sum < 2^SW
  localparam int unsigned PW = SW + DK;
  localparam logic [DK-1:0] DIV3_M = DK'(((64'd1 << DK) / 64'd3) + 64'd1);

  // Stage 1 registers
  logic          s1_valid_q;
  logic [CW-1:0] s1_r_q, s1_g_q, s1_b_q, s1_thr_q;
  logic [1:0]    s1_mode_q;
  // Stage 2 registers
  logic          s2_valid_q;
  logic [SW-1:0] s2_sum_q;
  logic [LW-1:0] s2_luma_q;
  logic [CW-1:0] s2_max_q, s2_thr_q;
  logic [1:0]    s2_mode_q;
  // Stage 3 registers
  logic          s3_valid_q;
  logic [CW-1:0] s3_data_q;

  logic          s1_load, s2_load, s3_load;
  logic [SW-1:0] s2_sum_d;
  logic [LW-1:0] s2_luma_d;
  logic [CW-1:0] s2_max_d;
  logic [PW-1:0] div_prod;
  logic [CW-1:0] avg, res_d;

  // A stage loads when empty or when its contents move on this edge.
  assign s3_load  = !s3_valid_q || out_ready;
  assign s2_load  = !s2_valid_q || s3_load;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;

  always_comb begin
    s2_sum_d  = SW'(s1_r_q) + SW'(s1_g_q) + SW'(s1_b_q);
    s2_luma_d = LW'(77) * LW'(s1_r_q) + LW'(150) * LW'(s1_g_q) + LW'(29) * LW'(s1_b_q);
    s2_max_d  = s1_r_q;
    if (s1_g_q > s2_max_d) s2_max_d = s1_g_q;
    if (s1_b_q > s2_max_d) s2_max_d = s1_b_q;
  end

  always_comb begin
    div_prod = PW'(s2_sum_q) * PW'(DIV3_M);
    avg      = CW'(div_prod >> DK);
    res_d    = '0;
    case (s2_mode_q)
      2'd0:    res_d = avg;
      2'd1:    res_d = CW'(s2_luma_q >> 8);
      2'd2:    res_d = s2_max_q;
      default: res_d = (avg >= s2_thr_q) ? {CW{1'b1}} : '0;
    endcase
    if (ZERO_SUB != 0 && res_d == '0) res_d = CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_thr_q   <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_luma_q  <= '0;
      s2_max_q   <= '0;
      s2_thr_q   <= '0;
      s2_mode_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_r_q    <= in_pixel[3*CW-1:2*CW];
          s1_g_q    <= in_pixel[2*CW-1:CW];
          s1_b_q    <= in_pixel[CW-1:0];
          s1_mode_q <= in_mode;
          s1_thr_q  <= in_thr;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sum_q  <= s2_sum_d;
          s2_luma_q <= s2_luma_d;
          s2_max_q  <= s2_max_d;
          s2_mode_q <= s1_mode_q;
          s2_thr_q  <= s1_thr_q;
        end
      end
      if (s3_load) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) s3_data_q <= res_d;
      end
    end
  end

`ifdef BW_STREAM_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_stats) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign pix_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_stats;
  assign pix_cnt    = '0;
`endif

endmodule

// File: tb/tb_bw_stream_filter.sv
// Scoreboard bench for bw_stream_filter: directed spec vectors, backpressure, reset and random traffic.
// Counter checks adapt to whether BW_STREAM_STATS_EN is defined.
module tb_bw_stream_filter;
  localparam int unsigned CW = 8;
  localparam int unsigned ZS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_pixel = '0;
  logic [1:0]  in_mode = '0;
  logic [7:0]  in_thr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        clr_stats = 1'b0;
  logic [31:0] pix_cnt;

  bw_stream_filter #(.CW(CW), .ZERO_SUB(ZS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_mode(in_mode), .in_thr(in_thr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .clr_stats(clr_stats), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    int         cyc;
    logic       lat;
  } exp_t;

  typedef struct packed {
    logic [23:0] p;
    logic [1:0]  m;
    logic [7:0]  t;
    logic [7:0]  e;
  } vec_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rdy_mode = 0;  // 0 always ready, 1 fixed pattern, 2 random, 3 manual
  int         bp_idx = 0;
  logic [6:0] bp_bits = 7'b1010000;  // cycle 0..6: 0,0,0,0,1,0,1 then 1
  int         n_acc = 0;
  int         first_refuse = -1;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic [7:0] zero_res;
  vec_t       vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_model(input logic [23:0] p, input logic [1:0] m,
                                           input logic [7:0] t);
    int r, g, b, s, v;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    s = r + g + b;
    case (m)
      2'd0: v = s / 3;
      2'd1: v = (77 * r + 150 * g + 29 * b) / 256;
      2'd2: begin
        v = (r > g) ? r : g;
        v = (v > b) ? v : b;
      end
      default: v = (s / 3 >= int'(t)) ? 255 : 0;
    endcase
    if (ZS != 0 && v == 0) v = 1;
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (bp_idx < 7) ? bp_bits[bp_idx] : 1'b1;
        bp_idx++;
      end
      2: out_ready = ($urandom_range(0, 9) < 7);
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cycle();
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [23:0] p, input logic [1:0] m, input logic [7:0] t,
                      input logic [7:0] e);
    bit done = 0;
    int n = 0;
    while (!done && n < 200) begin
      cycle();
      in_valid = 1'b1;
      in_pixel = p;
      in_mode  = m;
      in_thr   = t;
      #1;
      if (in_ready) begin
        exp_q.push_back('{data: e, cyc: cyc, lat: (rdy_mode == 0)});
        n_acc++;
        done = 1;
      end else if (first_refuse < 0) begin
        first_refuse = n_acc;
      end
      n++;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle();
      in_valid = 1'b0;
      #3;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 32'd0);
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'd0, out_data}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e.data});
          if (e.lat) check("latency", cyc - e.cyc, 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] p;
    logic [1:0]  m;
    logic [7:0]  t;
    logic [7:0]  ch [3];

    zero_res = (ZS != 0) ? 8'h01 : 8'h00;
    vecs[0]  = '{p: 24'h306090, m: 2'd0, t: 8'h00, e: 8'h60};
    vecs[1]  = '{p: 24'hFFFFFF, m: 2'd0, t: 8'h00, e: 8'hFF};
    vecs[2]  = '{p: 24'hFEFFFF, m: 2'd0, t: 8'h00, e: 8'hFE};
    vecs[3]  = '{p: 24'h010100, m: 2'd0, t: 8'h00, e: zero_res};
    vecs[4]  = '{p: 24'h000000, m: 2'd0, t: 8'h00, e: zero_res};
    vecs[5]  = '{p: 24'hFF0000, m: 2'd1, t: 8'h00, e: 8'h4C};
    vecs[6]  = '{p: 24'h00FF00, m: 2'd1, t: 8'h00, e: 8'h95};
    vecs[7]  = '{p: 24'h0000FF, m: 2'd1, t: 8'h00, e: 8'h1C};
    vecs[8]  = '{p: 24'hFFFFFF, m: 2'd1, t: 8'h00, e: 8'hFF};
    vecs[9]  = '{p: 24'h10A020, m: 2'd2, t: 8'h80, e: 8'hA0};
    vecs[10] = '{p: 24'h306090, m: 2'd3, t: 8'h80, e: zero_res};
    vecs[11] = '{p: 24'h8080FF, m: 2'd3, t: 8'h80, e: 8'hFF};

    // Power-on reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_pix_cnt", pix_cnt, 32'd0);

    // Reset with two pixels in flight
    rdy_mode = 0;
    send(24'h306090, 2'd0, 8'h00, 8'h60);
    send(24'hFFFFFF, 2'd0, 8'h00, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_pix_cnt", pix_cnt, 32'd0);
    idle(6);
    #1;
    check("midrst_no_output", {31'd0, out_valid}, 32'd0);

    // Directed vectors, back to back, always ready
    for (int i = 0; i < 12; i++) send(vecs[i].p, vecs[i].m, vecs[i].t, vecs[i].e);
    drain();

    // Backpressure: 8 back-to-back pixels against a fixed out_ready pattern
    do_reset();
    rdy_mode = 1;
    bp_idx = 0;
    n_acc = 0;
    first_refuse = -1;
    for (int i = 0; i < 8; i++) begin
      p = 24'($urandom);
      m = 2'($urandom_range(0, 3));
      t = 8'($urandom);
      send(p, m, t, ref_model(p, m, t));
    end
    check("bp_fill_count", first_refuse, 32'd3);
    drain();
`ifdef BW_STREAM_STATS_EN
    check("bp_pix_cnt", pix_cnt, 32'd8);
`else
    check("bp_pix_cnt_tied", pix_cnt, 32'd0);
`endif

    // Random traffic with random backpressure and input gaps
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      for (int c = 0; c < 3; c++) begin
        case ($urandom_range(0, 3))
          0: ch[c] = 8'h00;
          1: ch[c] = 8'hFF;
          default: ch[c] = 8'($urandom);
        endcase
      end
      p = {ch[0], ch[1], ch[2]};
      m = 2'($urandom_range(0, 3));
      t = 8'($urandom);
      send(p, m, t, ref_model(p, m, t));
    end
    rdy_mode = 0;
    drain();

`ifdef BW_STREAM_STATS_EN
    // Counter wrap from preloaded all-ones
    @(negedge clk);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    #1;
    check("cnt_preload", pix_cnt, 32'hFFFFFFFF);
    send(24'h123456, 2'd2, 8'h00, 8'h56);
    drain();
    check("cnt_wrap", pix_cnt, 32'd0);
    send(24'h404040, 2'd0, 8'h00, 8'h40);
    drain();
    check("cnt_inc", pix_cnt, 32'd1);
    // clr_stats on the same edge as an output transfer
    rdy_mode = 3;
    @(negedge clk);
    out_ready = 1'b0;
    send(24'h808080, 2'd0, 8'h00, 8'h80);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        cycle();
        in_valid = 1'b0;
        #1;
        if (out_valid) seen = 1;
      end
      if (!seen) check("clr_wait_timeout", 32'd0, 32'd1);
    end
    out_ready = 1'b1;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    #1;
    check("cnt_clr_priority", pix_cnt, 32'd0);
    rdy_mode = 0;
    drain();
`else
    clr_stats = 1'b1;
    send(24'h123456, 2'd2, 8'h00, 8'h56);
    drain();
    clr_stats = 1'b0;
    check("cnt_tied_after_traffic", pix_cnt, 32'd0);
`endif

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
